// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one Stein GCD engine among NREQ requesters.
// Each job restarts the engine through eng_rst_n and is guarded by a watchdog timer.
module gcd_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int USIZE   = 6,
    parameter int VSIZE   = 5,
    parameter int TIMEOUT = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*USIZE-1:0] u_in,
    input  logic [NREQ*VSIZE-1:0] v_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [USIZE-1:0]      rsp_gcd,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_rst_n,
    output logic [USIZE-1:0]      eng_u,
    output logic [VSIZE-1:0]      eng_v,
    input  logic                  eng_done,
    input  logic [USIZE-1:0]      eng_gcd
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic                zero_q, zero_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [USIZE-1:0]    rsp_gcd_q, rsp_gcd_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic                eng_rst_n_q, eng_rst_n_d;
    logic [USIZE-1:0]    eng_u_q, eng_u_d;
    logic [VSIZE-1:0]    eng_v_q, eng_v_d;

    logic [USIZE-1:0]    u_arr [NREQ];
    logic [VSIZE-1:0]    v_arr [NREQ];
    logic [PW-1:0]       cand;
    logic [PW-1:0]       grant_idx;
    logic                grant_any;
    logic [USIZE-1:0]    u_sel;
    logic [VSIZE-1:0]    v_sel;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            u_arr[i] = u_in[i*USIZE +: USIZE];
            v_arr[i] = v_in[i*VSIZE +: VSIZE];
        end
    end

    // NOTE: every variable written in always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Scan from lowest to highest priority so the nearest request at or after ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
    end

    assign u_sel = u_arr[grant_idx];
    assign v_sel = v_arr[grant_idx];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        zero_d      = zero_q;
        timer_d     = timer_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_gcd_d   = rsp_gcd_q;
        rsp_err_d   = rsp_err_q;
        eng_u_d     = eng_u_q;
        eng_v_d     = eng_v_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    grant_d = grant_idx;
                    eng_u_d = u_sel;
                    eng_v_d = v_sel;
                    zero_d  = (u_sel == '0) && (v_sel == '0);
                    ack_d   = ONE << grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                // A 0/0 job never releases the engine; it is answered with an error here.
                if (zero_q) begin
                    rsp_valid_d = ONE << grant_q;
                    rsp_gcd_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (eng_done) begin
                    rsp_valid_d = ONE << grant_q;
                    rsp_gcd_d   = eng_gcd;
                    rsp_err_d   = 1'b0;
                    state_d     = RESPOND;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    rsp_valid_d = ONE << grant_q;
                    rsp_gcd_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                ptr_d   = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        eng_rst_n_d = (state_d == WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values; all control and output flops are reset, so the engine is parked
    // the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            zero_q      <= 1'b0;
            timer_q     <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_gcd_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            eng_rst_n_q <= 1'b0;
            eng_u_q     <= '0;
            eng_v_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            zero_q      <= zero_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_gcd_q   <= rsp_gcd_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            eng_rst_n_q <= eng_rst_n_d;
            eng_u_q     <= eng_u_d;
            eng_v_q     <= eng_v_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_gcd   = rsp_gcd_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign eng_rst_n = eng_rst_n_q;
    assign eng_u     = eng_u_q;
    assign eng_v     = eng_v_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler with a behavioural engine and a response scoreboard.
// Expected results are queued at grant time and compared when rsp_valid fires.
module tb_gcd_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int USIZE   = 6;
    localparam int VSIZE   = 5;
    localparam int TIMEOUT = 63;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*USIZE-1:0] u_in;
    logic [NREQ*VSIZE-1:0] v_in;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [USIZE-1:0]      rsp_gcd;
    logic                  rsp_err;
    logic                  busy;
    logic                  eng_rst_n;
    logic [USIZE-1:0]      eng_u;
    logic [VSIZE-1:0]      eng_v;
    logic                  eng_done;
    logic [USIZE-1:0]      eng_gcd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int idx;
        int gcd;
        bit err;
    } exp_t;

    exp_t sb[$];

    gcd_rr_scheduler #(
        .NREQ(NREQ), .USIZE(USIZE), .VSIZE(VSIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .u_in(u_in), .v_in(v_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
        .busy(busy), .eng_rst_n(eng_rst_n), .eng_u(eng_u), .eng_v(eng_v),
        .eng_done(eng_done), .eng_gcd(eng_gcd)
    );

    always #5 clk = ~clk;

    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: counts cycles out of reset, raises done after done_delay cycles.
    int eng_cnt;
    bit eng_en;
    int done_delay;

    always @(posedge clk or negedge eng_rst_n) begin
        if (!eng_rst_n) eng_cnt <= 0;
        else            eng_cnt <= eng_cnt + 1;
    end

    assign eng_done = eng_en && eng_rst_n && (eng_cnt >= done_delay);
    assign eng_gcd  = eng_done ? USIZE'(gcd_ref(int'(eng_u), int'(eng_v))) : '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                n = i;
                break;
            end
        end
        check("ack_seen", 32'(ack != '0), 1);
    endtask

    task automatic wait_rsp(input int budget, output int n, output bit rose);
        n    = 0;
        rose = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) check("ack_pulse", ack, 0);
            if (eng_rst_n === 1'b1) rose = 1'b1;
            if (rsp_valid != '0) begin
                n = i;
                break;
            end
        end
        check("rsp_seen", 32'(rsp_valid != '0), 1);
    endtask

    task automatic compare_rsp();
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, 1 << e.idx);
        check("rsp_gcd", rsp_gcd, e.gcd);
        check("rsp_err", rsp_err, 32'(e.err));
    endtask

    task automatic push_exp(input int idx, input int g, input bit err);
        exp_t e;
        e.idx = idx;
        e.gcd = g;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int idx, input int u, input int v);
        u_in[idx*USIZE +: USIZE] = USIZE'(u);
        v_in[idx*VSIZE +: VSIZE] = VSIZE'(v);
    endtask

    // One isolated job from IDLE: ack timing, engine handshake, latency and result.
    task automatic run_job(input int idx, input int u, input int v, input bit en, input int delay);
        bit zero;
        bit tmo;
        int exp_g;
        bit exp_e;
        int exp_lat;
        int n;
        bit rose;
        zero = (u == 0) && (v == 0);
        tmo  = !en || (delay > TIMEOUT);
        if (zero) begin
            exp_g = 0; exp_e = 1'b1; exp_lat = 1;
        end else if (tmo) begin
            exp_g = 0; exp_e = 1'b1; exp_lat = TIMEOUT + 2;
        end else begin
            exp_g = gcd_ref(u, v); exp_e = 1'b0; exp_lat = delay + 2;
        end
        eng_en     = en;
        done_delay = delay;
        set_ops(idx, u, v);
        req      = '0;
        req[idx] = 1'b1;
        @(negedge clk);
        check("ack", ack, 1 << idx);
        check("busy_issue", busy, 1);
        check("eng_rst_issue", eng_rst_n, 0);
        check("eng_u", eng_u, u);
        check("eng_v", eng_v, v);
        push_exp(idx, exp_g, exp_e);
        req = '0;
        wait_rsp(200, n, rose);
        check("latency", n, exp_lat);
        check("eng_released", 32'(rose), 32'(!zero));
        check("eng_u_hold", eng_u, u);
        compare_rsp();
        @(negedge clk);
        check("rsp_pulse", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_eng_rst", eng_rst_n, 0);
        check("gcd_hold", rsp_gcd, exp_g);
    endtask

    int fu[NREQ] = '{12, 45, 49, 60};
    int fv[NREQ] = '{8, 27, 14, 25};

    initial begin
        int n;
        bit rose;
        int gi;

        rst_n      = 1'b0;
        req        = '0;
        u_in       = '0;
        v_in       = '0;
        eng_en     = 1'b0;
        done_delay = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_gcd", rsp_gcd, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_rst_n", eng_rst_n, 0);
        check("rst_eng_u", eng_u, 0);
        check("rst_eng_v", eng_v, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all four requesters held high, grants rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_ops(i, fu[i], fv[i]);
        eng_en     = 1'b1;
        done_delay = 3;
        req        = '1;
        for (int j = 0; j < 5; j++) begin
            wait_ack(10, n);
            gi = j % NREQ;
            check("fair_grant", ack, 1 << gi);
            check("fair_eng_u", eng_u, fu[gi]);
            push_exp(gi, gcd_ref(fu[gi], fv[gi]), 1'b0);
            if (j == 4) req = '0;
            wait_rsp(20, n, rose);
            compare_rsp();
        end
        @(negedge clk);

        // Single job, timeout, zero operands, edge operands, done on the timeout cycle.
        run_job(0, 48, 18, 1'b1, 8);
        run_job(2, 35, 21, 1'b0, 0);
        run_job(1, 0, 0, 1'b1, 0);
        run_job(3, 0, 30, 1'b1, 5);
        run_job(0, 50, 25, 1'b1, 2);
        run_job(2, 36, 24, 1'b1, TIMEOUT);

        // Reset in the middle of WAIT drops the job; requester 0 is served first after.
        eng_en = 1'b0;
        set_ops(3, 33, 11);
        req = 4'b1000;
        @(negedge clk);
        check("mid_ack", ack, 4'b1000);
        repeat (5) @(negedge clk);
        check("mid_wait", eng_rst_n, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_gcd", rsp_gcd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_eng_rst_n", eng_rst_n, 0);
        check("mid_rst_eng_u", eng_u, 0);
        set_ops(0, 40, 24);
        req        = 4'b1001;
        eng_en     = 1'b1;
        done_delay = 2;
        @(negedge clk);
        check("mid_hold_rsp", rsp_valid, 0);
        check("mid_hold_busy", busy, 0);
        rst_n = 1'b1;
        wait_ack(10, n);
        check("post_rst_grant", ack, 4'b0001);
        push_exp(0, gcd_ref(40, 24), 1'b0);
        req = 4'b1000;
        wait_rsp(20, n, rose);
        compare_rsp();
        wait_ack(10, n);
        check("post_rst_next", ack, 4'b1000);
        push_exp(3, gcd_ref(33, 11), 1'b0);
        req = '0;
        wait_rsp(20, n, rose);
        compare_rsp();
        @(negedge clk);
        check("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
